loop_gain_sequencer: RTL and testbench
======================================

# loop_gain_sequencer

Gear-shifting controller for the carrier/bit-sync loop filter gains. It watches the 8-bit signed loop phase error and drives the lead- and lag-path gain exponents. Acquisition gains are applied first; once lock is detected the exponents are stepped one unit at a time to tracking values. Loss of lock snaps them back to acquisition values. It sits beside the lead-gain and lag-gain stages and owns their `leadExp`/`lagExp` controls.

## Interface
- `CNT_W`, default 16: width of the lock/loss run counters and their thresholds.
- `clk  input  1`: system clock.
- `reset  input  1`: asynchronous, active-low reset (low = reset).
- `clkEn  input  1`: sample enable. All state, counters and outputs advance only on `clk` edges with `clkEn`=1.
- `loopEn  input  1`: loop enable. When 0, the block is held in ACQ with counters cleared and both exponent outputs forced to 0.
- `error  input  8`: signed two's-complement loop phase error, one sample per `clkEn`.
- `acqLeadExp`, `acqLagExp`  input  5 each: acquisition exponents.
- `trkLeadExp`, `trkLagExp`  input  5 each: tracking exponents.
- `lockThresh  input  8`: unsigned magnitude threshold.
- `lockCount  input  CNT_W`: consecutive in-lock samples needed to declare lock. A value of 0 behaves as 1.
- `lossCount  input  CNT_W`: consecutive out-of-lock samples needed to declare loss. A value of 0 behaves as 1.
- `stepDwell  input  8`: `clkEn` samples between exponent steps. A value of 0 behaves as 1.
- `leadExp`, `lagExp`  output  5 each: registered exponents to the gain stages.
- `locked  output  1`: registered; 1 only in TRACK.
- `state  output  2`: registered. ACQ=0, SHIFT=1, TRACK=2. Value 3 is illegal and recovers to ACQ on the next `clkEn`.

## Operation
**Magnitude and sample classification**
- `mag` = |`error|` as 8-bit unsigned; -128 gives 128.
- A sample is in-lock when `mag < lockThresh`, otherwise out-of-lock. With `lockThresh`=0, lock is never declared.

**Run counters**
- `inRun` counts consecutive in-lock samples. It clears on any out-of-lock sample and saturates at all-ones.
- `outRun` counts consecutive out-of-lock samples. It clears on any in-lock sample and saturates at all-ones.
- Both counters clear on every state transition.

**ACQ state**
- `leadExp`/`lagExp` follow `acqLeadExp`/`acqLagExp` live, registered, each `clkEn`.
- On the `clkEn` edge where the current sample makes `inRun` reach `lockCount`, the state goes to SHIFT. The exponent registers keep their acquisition values and the dwell counter clears.

**SHIFT state**
- The dwell counter increments each `clkEn`.
- When it reaches `stepDwell`-1, it wraps to 0 and each exponent moves by exactly 1 toward its tracking target. Stepping is up or down as needed. An exponent already at its target holds.
- If both next exponent values equal their targets, the state goes to TRACK on that same edge. This also covers entry with acquisition exponents equal to tracking exponents: TRACK is reached at the first dwell expiry.
- If `outRun` reaches `lossCount` while in SHIFT, the state goes to ACQ. Exponents load the acquisition values on that edge.
- Target values are read live, so a target change during SHIFT redirects the stepping.

**TRACK state**
- `leadExp`/`lagExp` follow `trkLeadExp`/`trkLagExp` live. `locked`=1.
- On the edge where `outRun` reaches `lossCount`, the state goes to ACQ, `locked` goes to 0, and the exponents load the acquisition values on the same edge.

**Loop enable**
- `loopEn`=0 is synchronous and gated by `clkEn`. It forces state=ACQ, clears all counters, and sets `leadExp`=`lagExp`=0.
- It takes priority over every other transition.

**Exponent arithmetic**
- Exponents are unsigned 5-bit and never wrap. Stepping toward a target in 0..31 cannot overflow.

## Timing
**Reset**
- Values while `reset`=0: state=ACQ, `leadExp`=0, `lagExp`=0, `locked`=0, all counters 0.
- After reset releases, outputs take acquisition values on the first `clkEn` edge with `loopEn`=1.

**Latency**
- All outputs are registered. Sample n presented with `clkEn` affects the outputs at the end of that same edge, so latency is 1 `clk`.
- No combinational path exists from any input to any output.

**Step timing**
- With `stepDwell`=D, the k-th exponent step occurs on the (k·D)-th `clkEn` edge after entry to SHIFT.

**Simultaneous events and mid-operation reset**
- If a dwell expiry and loss-of-lock fall on the same edge, loss wins.
- If `reset` asserts mid-SHIFT, outputs go to 0 immediately (asynchronously).

## Test plan
- **Acquire and shift.** Settings: `acqLead`=0x10, `trkLead`=0x0C, `acqLag`=0x14, `trkLag`=0x0E, `lockThresh`=8, `lockCount`=4, `stepDwell`=2. Stimulus: `error`=3 on every `clkEn`.
  - Expected: SHIFT after the 4th sample.
  - `leadExp` goes 0x0F, 0x0E, 0x0D, 0x0C at entry+2, +4, +6, +8.
  - `lagExp` goes 0x13 down to 0x0E at entry+2..+12.
  - TRACK and `locked`=1 at entry+12.
- **Run reset.** `lockCount`=4 with `error` sequence 3,3,3,20,3,3,3,3. Expected: SHIFT only after the 8th sample.
- **Loss of lock.** In TRACK with `lossCount`=3, apply `error`=-128 (`mag`=128) three times. Expected: ACQ on the 3rd, `locked`=0, exponents equal 0x10/0x14 on the same edge.
- **Upward stepping and loss during SHIFT.**
  - With `acqLead`=0x08 and `trkLead`=0x0A: `leadExp` steps upward 0x09, 0x0A.
  - Abort SHIFT with `lossCount` out-of-lock samples. Expected: ACQ, and the dwell counter restarts on re-entry.
- **Enable and clock enable.** In TRACK, drive `loopEn`=0 for one `clkEn`. Expected: outputs 0, state ACQ. Holding `clkEn`=0 with changing `error` must freeze all state.
- **Reset mid-SHIFT and degenerate settings.** Assert `reset` mid-SHIFT. Expected: outputs 0 within the same cycle. Then with `lockCount`=0 and `stepDwell`=0, one in-lock sample enters SHIFT and each subsequent `clkEn` steps.

Source files
------------

// File: rtl/loop_gain_sequencer.sv
// Loop-filter gain gear shifter: holds acquisition exponents until lock, walks them
// one unit per dwell period to the tracking exponents, and snaps back on loss of lock.
module loop_gain_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkEn,
  input  logic             loopEn,
  input  logic [7:0]       error,
  input  logic [4:0]       acqLeadExp,
  input  logic [4:0]       acqLagExp,
  input  logic [4:0]       trkLeadExp,
  input  logic [4:0]       trkLagExp,
  input  logic [7:0]       lockThresh,
  input  logic [CNT_W-1:0] lockCount,
  input  logic [CNT_W-1:0] lossCount,
  input  logic [7:0]       stepDwell,
  output logic [4:0]       leadExp,
  output logic [4:0]       lagExp,
  output logic             locked,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    SHIFT = 2'd1,
    TRACK = 2'd2,
    BAD   = 2'd3
  } seqState_t;

  seqState_t        stateQ, stateN;
  logic [4:0]       leadQ, leadN, lagQ, lagN;
  logic             lockedQ, lockedN;
  logic [CNT_W-1:0] inRunQ, inRunN, outRunQ, outRunN;
  logic [7:0]       dwellQ, dwellN;

  logic [7:0]       mag;
  logic             inLock;
  logic [CNT_W-1:0] inRunInc, outRunInc;
  logic [CNT_W-1:0] lockLimit, lossLimit;
  logic [7:0]       dwellLimit;
  logic             lockHit, lossHit, dwellHit;
  logic [4:0]       stepLead, stepLag;

  // -128 negates to 8'h80, which reads as 128 unsigned.
  assign mag    = error[7] ? (~error + 8'd1) : error;
  assign inLock = mag < lockThresh;

  assign inRunInc  = (&inRunQ)  ? inRunQ  : inRunQ  + CNT_W'(1);
  assign outRunInc = (&outRunQ) ? outRunQ : outRunQ + CNT_W'(1);

  assign lockLimit  = (lockCount == '0) ? CNT_W'(1) : lockCount;
  assign lossLimit  = (lossCount == '0) ? CNT_W'(1) : lossCount;
  assign dwellLimit = (stepDwell == '0) ? 8'd1 : stepDwell;

  // Thresholds compare against the post-sample run length so the hit lands on that edge.
  assign lockHit  = inLock  && ((inRunInc)  >= lockLimit);
  assign lossHit  = !inLock && ((outRunInc) >= lossLimit);
  assign dwellHit = dwellQ >= (dwellLimit - 8'd1);

  assign stepLead = (leadQ < trkLeadExp) ? leadQ + 5'd1 :
                    (leadQ > trkLeadExp) ? leadQ - 5'd1 : leadQ;
  assign stepLag  = (lagQ < trkLagExp)   ? lagQ + 5'd1 :
                    (lagQ > trkLagExp)   ? lagQ - 5'd1 : lagQ;

  always_comb begin
    stateN  = stateQ;
    leadN   = leadQ;
    lagN    = lagQ;
    dwellN  = '0;
    inRunN  = inLock ? inRunInc : '0;
    outRunN = inLock ? '0 : outRunInc;

    case (stateQ)
      ACQ: begin
        leadN = acqLeadExp;
        lagN  = acqLagExp;
        if (lockHit) stateN = SHIFT;
      end
      SHIFT: begin
        if (lossHit) begin
          stateN = ACQ;
          leadN  = acqLeadExp;
          lagN   = acqLagExp;
        end else if (dwellHit) begin
          leadN = stepLead;
          lagN  = stepLag;
          if ((stepLead == trkLeadExp) && (stepLag == trkLagExp)) stateN = TRACK;
        end else begin
          dwellN = dwellQ + 8'd1;
        end
      end
      TRACK: begin
        leadN = trkLeadExp;
        lagN  = trkLagExp;
        if (lossHit) begin
          stateN = ACQ;
          leadN  = acqLeadExp;
          lagN   = acqLagExp;
        end
      end
      default: begin
        stateN = ACQ;
        leadN  = acqLeadExp;
        lagN   = acqLagExp;
      end
    endcase

    if (stateN != stateQ) begin
      inRunN  = '0;
      outRunN = '0;
    end

    if (!loopEn) begin
      stateN  = ACQ;
      leadN   = '0;
      lagN    = '0;
      dwellN  = '0;
      inRunN  = '0;
      outRunN = '0;
    end

    lockedN = (stateN == TRACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= ACQ;
      leadQ   <= '0;
      lagQ    <= '0;
      lockedQ <= 1'b0;
      inRunQ  <= '0;
      outRunQ <= '0;
      dwellQ  <= '0;
    end else if (clkEn) begin
      stateQ  <= stateN;
      leadQ   <= leadN;
      lagQ    <= lagN;
      lockedQ <= lockedN;
      inRunQ  <= inRunN;
      outRunQ <= outRunN;
      dwellQ  <= dwellN;
    end
  end

  assign leadExp = leadQ;
  assign lagExp  = lagQ;
  assign locked  = lockedQ;
  assign state   = stateQ;

endmodule

// File: tb/tb_loop_gain_sequencer.sv
// Bench for loop_gain_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_loop_gain_sequencer;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clkEn = 1'b0;
  logic        loopEn = 1'b1;
  logic [7:0]  error = '0;
  logic [4:0]  acqLeadExp = 5'h10, acqLagExp = 5'h14;
  logic [4:0]  trkLeadExp = 5'h0C, trkLagExp = 5'h0E;
  logic [7:0]  lockThresh = 8'd8;
  logic [15:0] lockCount = 16'd4, lossCount = 16'd3;
  logic [7:0]  stepDwell = 8'd2;
  logic [4:0]  leadExp, lagExp;
  logic        locked;
  logic [1:0]  state;

  int nCmp = 0;
  int nFail = 0;

  // Model: mode 0/1/2 = ACQ/SHIFT/TRACK; mSince counts edges since SHIFT entry or last step.
  int mMode = 0, mIn = 0, mOut = 0, mSince = 0, mLead = 0, mLag = 0;

  loop_gain_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .loopEn(loopEn), .error(error),
    .acqLeadExp(acqLeadExp), .acqLagExp(acqLagExp),
    .trkLeadExp(trkLeadExp), .trkLagExp(trkLagExp),
    .lockThresh(lockThresh), .lockCount(lockCount), .lossCount(lossCount),
    .stepDwell(stepDwell), .leadExp(leadExp), .lagExp(lagExp),
    .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic model_step();
    int e, m, prev, lockLim, lossLim, dw;
    if (!reset) begin
      mMode = 0; mIn = 0; mOut = 0; mSince = 0; mLead = 0; mLag = 0;
    end else if (clkEn) begin
      if (!loopEn) begin
        mMode = 0; mIn = 0; mOut = 0; mSince = 0; mLead = 0; mLag = 0;
      end else begin
        e = $signed(error);
        m = (e < 0) ? -e : e;
        if (m < int'(lockThresh)) begin
          mIn = (mIn < CMAX) ? mIn + 1 : CMAX;
          mOut = 0;
        end else begin
          mOut = (mOut < CMAX) ? mOut + 1 : CMAX;
          mIn = 0;
        end
        lockLim = (lockCount == 0) ? 1 : int'(lockCount);
        lossLim = (lossCount == 0) ? 1 : int'(lossCount);
        dw      = (stepDwell == 0) ? 1 : int'(stepDwell);
        prev = mMode;
        if (mMode == 0) begin
          mLead = acqLeadExp; mLag = acqLagExp;
          if (mIn >= lockLim) begin mMode = 1; mSince = 0; end
        end else if (mMode == 1) begin
          if (mOut >= lossLim) begin
            mMode = 0; mLead = acqLeadExp; mLag = acqLagExp;
          end else begin
            mSince++;
            if (mSince >= dw) begin
              mSince = 0;
              mLead = toward(mLead, int'(trkLeadExp));
              mLag  = toward(mLag, int'(trkLagExp));
              if (mLead == int'(trkLeadExp) && mLag == int'(trkLagExp)) mMode = 2;
            end
          end
        end else begin
          mLead = trkLeadExp; mLag = trkLagExp;
          if (mOut >= lossLim) begin
            mMode = 0; mLead = acqLeadExp; mLag = acqLagExp;
          end
        end
        if (mMode != prev) begin mIn = 0; mOut = 0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  // Every-cycle compare, packed as {state, leadExp, lagExp, locked}.
  initial forever begin
    logic [12:0] act, exp;
    @(negedge clk);
    act = {state, leadExp, lagExp, locked};
    exp = {2'(mMode), 5'(mLead), 5'(mLag), (mMode == 2)};
    check("cycle", 32'(act), 32'(exp));
  end

  task automatic sample(input logic [7:0] e);
    clkEn = 1'b1;
    error = e;
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    check("async_rst_lead", 32'(leadExp), 32'd0);
    check("async_rst_lag", 32'(lagExp), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic randomize_settings();
    lockThresh = 8'($urandom_range(0, 16));
    lockCount  = 16'($urandom_range(0, 5));
    lossCount  = 16'($urandom_range(0, 5));
    stepDwell  = 8'($urandom_range(0, 3));
    acqLeadExp = 5'($urandom_range(0, 31));
    acqLagExp  = 5'($urandom_range(0, 31));
    trkLeadExp = 5'($urandom_range(0, 31));
    trkLagExp  = 5'($urandom_range(0, 31));
  endtask

  initial begin
    logic [7:0] runSeq [8];
    int v;
    runSeq = '{8'd3, 8'd3, 8'd3, 8'd20, 8'd3, 8'd3, 8'd3, 8'd3};

    repeat (2) @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_lead", 32'(leadExp), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    reset = 1'b1;

    // Acquire and shift.
    repeat (3) sample(8'd3);
    check("acq_state_3", 32'(state), 32'd0);
    sample(8'd3);
    check("shift_entry", 32'(state), 32'd1);
    check("shift_entry_lead", 32'(leadExp), 32'h10);
    for (int k = 1; k <= 12; k++) begin
      sample(8'd3);
      check("shift_lead", 32'(leadExp), 32'((16 - k / 2 > 12) ? 16 - k / 2 : 12));
      check("shift_lag", 32'(lagExp), 32'(20 - k / 2));
      check("shift_state", 32'(state), (k == 12) ? 32'd2 : 32'd1);
    end
    check("track_locked", 32'(locked), 32'd1);

    // Loss of lock from TRACK.
    sample(8'h80);
    sample(8'h80);
    check("loss_still_track", 32'(state), 32'd2);
    sample(8'h80);
    check("loss_state", 32'(state), 32'd0);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_lead", 32'(leadExp), 32'h10);
    check("loss_lag", 32'(lagExp), 32'h14);

    // Run reset by an out-of-lock sample.
    for (int i = 0; i < 8; i++) begin
      sample(runSeq[i]);
      if (i == 6) check("run_reset_7", 32'(state), 32'd0);
    end
    check("run_reset_8", 32'(state), 32'd1);
    repeat (3) sample(8'd50);
    check("abort_shift", 32'(state), 32'd0);

    // Upward stepping, abort, re-entry with dwell restart.
    acqLeadExp = 5'h08; trkLeadExp = 5'h0A;
    acqLagExp  = 5'h0E; trkLagExp  = 5'h0E;
    stepDwell  = 8'd4;
    repeat (4) sample(8'd3);
    check("up_entry", 32'(state), 32'd1);
    repeat (4) sample(8'd3);
    check("up_step1", 32'(leadExp), 32'h09);
    repeat (3) sample(8'd50);
    check("up_abort_state", 32'(state), 32'd0);
    check("up_abort_lead", 32'(leadExp), 32'h08);
    repeat (4) sample(8'd3);
    check("up_reentry", 32'(state), 32'd1);
    repeat (3) sample(8'd3);
    check("up_dwell_restart", 32'(leadExp), 32'h08);
    sample(8'd3);
    check("up_step1_again", 32'(leadExp), 32'h09);
    repeat (4) sample(8'd3);
    check("up_step2", 32'(leadExp), 32'h0A);
    check("up_track", 32'(state), 32'd2);

    // Loop enable and clock enable.
    loopEn = 1'b0;
    sample(8'd3);
    check("dis_state", 32'(state), 32'd0);
    check("dis_lead", 32'(leadExp), 32'd0);
    check("dis_lag", 32'(lagExp), 32'd0);
    check("dis_locked", 32'(locked), 32'd0);
    loopEn = 1'b1;
    sample(8'd3);
    check("reen_lead", 32'(leadExp), 32'h08);
    clkEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      error = 8'(50 + i);
      @(negedge clk);
    end
    check("freeze_lead", 32'(leadExp), 32'h08);
    repeat (3) sample(8'd3);
    check("freeze_run_kept", 32'(state), 32'd1);

    // Reset mid-SHIFT, then degenerate settings.
    sample(8'd3);
    mid_reset();
    lockCount = 16'd0; stepDwell = 8'd0;
    acqLeadExp = 5'h10; acqLagExp = 5'h14;
    trkLeadExp = 5'h0C; trkLagExp = 5'h0E;
    sample(8'd3);
    check("degen_entry", 32'(state), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      sample(8'd3);
      check("degen_lead", 32'(leadExp), 32'((16 - k > 12) ? 16 - k : 12));
      check("degen_lag", 32'(lagExp), 32'(20 - k));
      check("degen_state", 32'(state), (k == 6) ? 32'd2 : 32'd1);
    end

    // Zero threshold never locks.
    loopEn = 1'b0;
    sample(8'd0);
    loopEn = 1'b1;
    lockThresh = 8'd0;
    repeat (5) sample(8'd0);
    check("thresh0_no_lock", 32'(state), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    randomize_settings();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) randomize_settings();
      if (i == 1500) mid_reset();
      clkEn  = ($urandom_range(0, 3) != 0);
      loopEn = ($urandom_range(0, 49) != 0);
      v = $urandom_range(0, 99);
      if (v < 70) begin
        v = $urandom_range(0, 10);
        error = ($urandom_range(0, 1) == 1) ? 8'(-v) : 8'(v);
      end else if (v < 75) begin
        error = 8'h80;
      end else begin
        error = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
